mem_burst_tester: RTL and testbench
===================================

# mem_burst_tester

Parametrised memory exercise engine between board controls and the Avalon-MM write and read master pair. It writes a burst of N generated words starting at a base address, reads it back, or does both and checks each word against the expected pattern. It reports an error count, the first failing address and the last word read. It succeeds the single-word, fixed-location, push-button read/write logic with burst length, mode selection, a data pattern seed and hardware compare.

## Interface
- ADDRESSWIDTH, 28, byte address width of both masters
- DATAWIDTH, 32, data word width
- BYTEENABLEWIDTH, 4, bytes per word; address stride per word
- MAXWORDS, 256, largest legal burst; count ports are CW = $clog2(MAXWORDS)+1 bits wide
- clk  in  1  sole clock
- reset  in  1  asynchronous, active-low reset
- start  in  1  one-cycle request; ignored unless idle
- mode  in  2  00 write-only, 01 read-only, 10 write-then-verify, 11 read-only with verify
- base_address  in  ADDRESSWIDTH  start byte address; low log2(BYTEENABLEWIDTH) bits forced to 0
- num_words  in  CW  burst length in words
- seed  in  DATAWIDTH  pattern seed; word i = seed + i, modulo 2^DATAWIDTH
- busy  out  1  high from the accepted start until done
- done  out  1  one-cycle pulse at completion
- cfg_error  out  1  last start had an illegal num_words
- error_count  out  16  compare mismatches, saturating at 16'hFFFF
- first_err_addr  out  ADDRESSWIDTH  address of the first mismatch
- last_read_data  out  DATAWIDTH  most recent word popped
- write_control_*, write_user_*  master write control and data ports; same names and meanings as the existing write master interface
- read_control_*, read_user_*  master read control and data ports; same names and meanings as the existing read master interface

## Operation
- All sampled inputs (mode, base, num_words, seed) are latched on the accepted start.
- States: IDLE, WR_GO, WR_DATA, WR_WAIT, RD_GO, RD_DATA, RD_WAIT, FINISH.
- IDLE + start:
  - num_words==0 or num_words>MAXWORDS: go to FINISH and set cfg_error.
  - Otherwise clear cfg_error and error_count, set first_err_addr to all ones, then go to WR_GO (mode 00/10) or RD_GO (mode 01/11).
- WR_GO:
  - write_control_go=1 for exactly one cycle.
  - write_control_write_base = latched base.
  - write_control_write_length = num_words*BYTEENABLEWIDTH.
  - write_control_fixed_location=0.
  - Next state is WR_DATA.
- WR_DATA: each cycle with !write_user_buffer_full, assert write_user_write_buffer with data seed+wcnt and increment wcnt. After word num_words-1, go to WR_WAIT.
- WR_WAIT: on write_control_done, go to RD_GO (mode 10) or FINISH (mode 00).
- RD_GO: read_control_go=1 for one cycle, with the same base and length and fixed_location=0.
- RD_DATA:
  - read_user_read_buffer = read_user_data_available && rcnt<num_words (combinational).
  - Data is valid in the same cycle as the pop (look-ahead FIFO).
  - Each pop loads last_read_data and increments rcnt.
  - In modes 10/11, a pop with data != seed+rcnt increments error_count. If it is the first mismatch, it also loads first_err_addr = base + rcnt*BYTEENABLEWIDTH.
  - After the last pop, go to RD_WAIT.
- RD_WAIT: go to FINISH when read_control_done is high; it may already be high on entry.
- FINISH: done=1 for one cycle, then IDLE.
- Address arithmetic is modulo 2^ADDRESSWIDTH; no bounds check. Pattern arithmetic is modulo 2^DATAWIDTH.

## Timing
- Reset values:
  - state IDLE
  - busy, done, cfg_error, all *_go, write_user_write_buffer and read_user_read_buffer = 0
  - error_count = 0
  - first_err_addr = all ones
  - last_read_data = 0
  - control bases, lengths and write data = 0
  - fixed_location = 0
- Reset mid-burst returns to IDLE immediately. The masters share this reset, so no recovery handshake is required.
- busy rises the cycle after start and falls the cycle after done.
- The go pulse comes 1 cycle after start. With write_user_buffer_full low, data words follow back-to-back at one per cycle.
- Illegal count: done is 2 cycles after start, and no master signal toggles.
- write_user_buffer_full asserted stalls WR_DATA with no write and wcnt held.
- A start during busy is dropped and has no effect on the latched config.
- A simultaneous pop and mismatch on the error_count saturation cycle leaves the count at FFFF.

## Test plan
- Mode 00, base 0x100, N=4, seed 0xDEAD0000, full=0 → go 1 cycle after start; words DEAD0000..DEAD0003 written on consecutive cycles; length=16; done after write_control_done.
- Mode 10, N=8, memory model echoes data → error_count=0, first_err_addr=0xFFFFFFF, last_read_data=seed+7.
- Mode 10, model corrupts word 3 and word 5 on readback, base 0x200 → error_count=2, first_err_addr=0x20C.
- Random write_user_buffer_full and read_user_data_available gaps, N=MAXWORDS → exactly 256 writes and 256 pops, no pop while data unavailable.
- N=0, then N=MAXWORDS+1 → cfg_error=1, done 2 cycles after start, no go pulses; a following legal start clears cfg_error.
- Reset asserted mid WR_DATA, then a new start → all outputs at reset values during reset; the new burst completes normally.

Source files
------------

// File: rtl/mem_burst_tester.sv
// Burst memory exerciser for an Avalon-MM write/read master pair.
// Writes seed+i patterns, reads them back and counts mismatches.
module mem_burst_tester #(
    parameter int ADDRESSWIDTH    = 28,
    parameter int DATAWIDTH       = 32,
    parameter int BYTEENABLEWIDTH = 4,
    parameter int MAXWORDS        = 256,
    localparam int CW             = $clog2(MAXWORDS) + 1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    start,
    input  logic [1:0]              mode,
    input  logic [ADDRESSWIDTH-1:0] base_address,
    input  logic [CW-1:0]           num_words,
    input  logic [DATAWIDTH-1:0]    seed,
    output logic                    busy,
    output logic                    done,
    output logic                    cfg_error,
    output logic [15:0]             error_count,
    output logic [ADDRESSWIDTH-1:0] first_err_addr,
    output logic [DATAWIDTH-1:0]    last_read_data,

    output logic                    write_control_fixed_location,
    output logic [ADDRESSWIDTH-1:0] write_control_write_base,
    output logic [ADDRESSWIDTH-1:0] write_control_write_length,
    output logic                    write_control_go,
    input  logic                    write_control_done,
    output logic                    write_user_write_buffer,
    output logic [DATAWIDTH-1:0]    write_user_buffer_data,
    input  logic                    write_user_buffer_full,

    output logic                    read_control_fixed_location,
    output logic [ADDRESSWIDTH-1:0] read_control_read_base,
    output logic [ADDRESSWIDTH-1:0] read_control_read_length,
    output logic                    read_control_go,
    input  logic                    read_control_done,
    output logic                    read_user_read_buffer,
    input  logic [DATAWIDTH-1:0]    read_user_buffer_data,
    input  logic                    read_user_data_available
);

    typedef enum logic [2:0] {
        IDLE,
        WR_GO,
        WR_DATA,
        WR_WAIT,
        RD_GO,
        RD_DATA,
        RD_WAIT,
        FINISH
    } state_t;

    localparam logic [ADDRESSWIDTH-1:0] STRIDE =
        ADDRESSWIDTH'(BYTEENABLEWIDTH);
    localparam logic [ADDRESSWIDTH-1:0] ALIGN = ~(STRIDE - 1'b1);

    state_t                  state;
    logic                    verify_q;
    logic [CW-1:0]           nw_q;
    logic [CW-1:0]           wcnt;
    logic [CW-1:0]           rcnt;
    logic [DATAWIDTH-1:0]    rexp;
    logic [ADDRESSWIDTH-1:0] raddr;

    logic                    bad_count;
    logic [ADDRESSWIDTH-1:0] base_in;
    logic [ADDRESSWIDTH-1:0] len_in;
    logic                    wr;
    logic                    pop;
    logic                    miss;

    assign bad_count = (num_words == '0) ||
                       (num_words > CW'(MAXWORDS));
    assign base_in = base_address & ALIGN;
    assign len_in  = ADDRESSWIDTH'(num_words) * STRIDE;

    assign wr   = (state == WR_DATA) && !write_user_buffer_full;
    assign pop  = (state == RD_DATA) && read_user_data_available &&
                  (rcnt < nw_q);
    assign miss = verify_q && (read_user_buffer_data != rexp);

    assign write_user_write_buffer      = wr;
    assign read_user_read_buffer        = pop;
    assign write_control_fixed_location = 1'b0;
    assign read_control_fixed_location  = 1'b0;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state                      <= IDLE;
            busy                       <= 1'b0;
            done                       <= 1'b0;
            cfg_error                  <= 1'b0;
            error_count                <= '0;
            first_err_addr             <= '1;
            last_read_data             <= '0;
            write_control_go           <= 1'b0;
            write_control_write_base   <= '0;
            write_control_write_length <= '0;
            write_user_buffer_data     <= '0;
            read_control_go            <= 1'b0;
            read_control_read_base     <= '0;
            read_control_read_length   <= '0;
            verify_q                   <= 1'b0;
            nw_q                       <= '0;
            wcnt                       <= '0;
            rcnt                       <= '0;
            rexp                       <= '0;
            raddr                      <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    busy <= 1'b0;
                    done <= 1'b0;
                    if (start) begin
                        busy     <= 1'b1;
                        verify_q <= mode[1];
                        nw_q     <= num_words;
                        if (bad_count) begin
                            cfg_error <= 1'b1;
                            state     <= FINISH;
                        end else begin
                            cfg_error                  <= 1'b0;
                            error_count                <= '0;
                            first_err_addr             <= '1;
                            write_control_write_base   <= base_in;
                            write_control_write_length <= len_in;
                            read_control_read_base     <= base_in;
                            read_control_read_length   <= len_in;
                            write_user_buffer_data     <= seed;
                            rexp                       <= seed;
                            raddr                      <= base_in;
                            wcnt                       <= '0;
                            rcnt                       <= '0;
                            if (mode[0]) begin
                                read_control_go <= 1'b1;
                                state           <= RD_GO;
                            end else begin
                                write_control_go <= 1'b1;
                                state            <= WR_GO;
                            end
                        end
                    end
                end
                WR_GO: begin
                    write_control_go <= 1'b0;
                    state            <= WR_DATA;
                end
                WR_DATA: begin
                    if (wr) begin
                        write_user_buffer_data <= write_user_buffer_data + 1'b1;
                        wcnt                   <= wcnt + CW'(1);
                        if (wcnt == nw_q - CW'(1))
                            state <= WR_WAIT;
                    end
                end
                WR_WAIT: begin
                    if (write_control_done) begin
                        if (verify_q) begin
                            read_control_go <= 1'b1;
                            state           <= RD_GO;
                        end else begin
                            state <= FINISH;
                        end
                    end
                end
                RD_GO: begin
                    read_control_go <= 1'b0;
                    state           <= RD_DATA;
                end
                RD_DATA: begin
                    if (pop) begin
                        last_read_data <= read_user_buffer_data;
                        rcnt           <= rcnt + CW'(1);
                        rexp           <= rexp + 1'b1;
                        raddr          <= raddr + STRIDE;
                        // count stays pinned at all ones once saturated
                        if (miss) begin
                            if (error_count != 16'hFFFF)
                                error_count <= error_count + 16'd1;
                            if (error_count == '0)
                                first_err_addr <= raddr;
                        end
                        if (rcnt == nw_q - CW'(1))
                            state <= RD_WAIT;
                    end
                end
                RD_WAIT: begin
                    if (read_control_done)
                        state <= FINISH;
                end
                FINISH: begin
                    done  <= 1'b1;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_burst_tester.sv
// Scoreboard bench for mem_burst_tester with random master back-pressure.
// A behavioural memory/master model feeds the DUT; a monitor checks outputs.
module tb_mem_burst_tester;

    localparam logic [31:0] CMASK = 32'h0100_0001;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [1:0]  mode;
    logic [27:0] base_address;
    logic [8:0]  num_words;
    logic [31:0] seed;
    logic        busy, done, cfg_error;
    logic [15:0] error_count;
    logic [27:0] first_err_addr;
    logic [31:0] last_read_data;
    logic        write_control_fixed_location;
    logic [27:0] write_control_write_base, write_control_write_length;
    logic        write_control_go, write_control_done;
    logic        write_user_write_buffer, write_user_buffer_full;
    logic [31:0] write_user_buffer_data;
    logic        read_control_fixed_location;
    logic [27:0] read_control_read_base, read_control_read_length;
    logic        read_control_go, read_control_done;
    logic        read_user_read_buffer, read_user_data_available;
    logic [31:0] read_user_buffer_data;

    always #5 clk = ~clk;

    mem_burst_tester dut (
        .clk(clk), .reset(rst_n), .start(start), .mode(mode),
        .base_address(base_address), .num_words(num_words), .seed(seed),
        .busy(busy), .done(done), .cfg_error(cfg_error),
        .error_count(error_count), .first_err_addr(first_err_addr),
        .last_read_data(last_read_data),
        .write_control_fixed_location(write_control_fixed_location),
        .write_control_write_base(write_control_write_base),
        .write_control_write_length(write_control_write_length),
        .write_control_go(write_control_go),
        .write_control_done(write_control_done),
        .write_user_write_buffer(write_user_write_buffer),
        .write_user_buffer_data(write_user_buffer_data),
        .write_user_buffer_full(write_user_buffer_full),
        .read_control_fixed_location(read_control_fixed_location),
        .read_control_read_base(read_control_read_base),
        .read_control_read_length(read_control_read_length),
        .read_control_go(read_control_go),
        .read_control_done(read_control_done),
        .read_user_read_buffer(read_user_read_buffer),
        .read_user_buffer_data(read_user_buffer_data),
        .read_user_data_available(read_user_data_available)
    );

    int n_checks = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    typedef struct {
        bit          cfg;
        logic [15:0] ec;
        logic [27:0] fa;
        logic [31:0] ld;
    } res_t;

    typedef struct {
        bit          wr;
        logic [27:0] base;
        logic [27:0] len;
    } go_t;

    logic [31:0] exp_wq[$];
    res_t        exp_res[$];
    go_t         exp_goq[$];

    logic [31:0] refmem[int unsigned];
    logic [31:0] mem[int unsigned];
    bit          corrupt[0:255];
    bit          gaps;

    bit          exp_cfg;
    logic [15:0] exp_ec;
    logic [27:0] exp_fa;
    logic [31:0] exp_ld;

    function automatic int unsigned wkey(input logic [27:0] b, input int i);
        return (int'(b >> 2) + i) & 32'h03FF_FFFF;
    endfunction

    // Reference: what the spec says each burst should produce.
    task automatic expect_burst(input logic [1:0] m, input logic [27:0] b,
                                input logic [8:0] nw, input logic [31:0] sd);
        logic [27:0] bm, len, fa;
        logic [31:0] rd;
        logic [15:0] ec;
        res_t r;
        if (nw == 0 || nw > 256) begin
            exp_cfg = 1'b1;
            r = '{1'b1, exp_ec, exp_fa, exp_ld};
            exp_res.push_back(r);
            return;
        end
        bm  = {b[27:2], 2'b00};
        len = 28'(nw) * 28'd4;
        if (!m[0]) begin
            exp_goq.push_back('{1'b1, bm, len});
            for (int i = 0; i < int'(nw); i++) begin
                exp_wq.push_back(sd + 32'(i));
                refmem[wkey(bm, i)] = sd + 32'(i);
            end
        end
        ec = 16'd0;
        fa = '1;
        if (m != 2'b00) begin
            exp_goq.push_back('{1'b0, bm, len});
            for (int i = 0; i < int'(nw); i++) begin
                rd = refmem.exists(wkey(bm, i)) ? refmem[wkey(bm, i)] : 32'h0;
                if (corrupt[i]) rd = rd ^ CMASK;
                exp_ld = rd;
                if (m[1] && rd != sd + 32'(i)) begin
                    if (ec == 0) fa = bm + 28'(i * 4);
                    if (ec != 16'hFFFF) ec = ec + 16'd1;
                end
            end
        end
        exp_cfg = 1'b0;
        exp_ec  = ec;
        exp_fa  = fa;
        r = '{1'b0, exp_ec, exp_fa, exp_ld};
        exp_res.push_back(r);
    endtask

    // Behavioural write/read master pair backed by a sparse memory.
    int          wr_total = 0, pop_total = 0;
    bit          wr_active, rd_active;
    int unsigned wr_base, rd_base;
    int          wr_n, wr_cnt, wr_delay, rd_n, rd_i, rd_cyc;

    initial begin
        write_user_buffer_full   = 1'b0;
        write_control_done       = 1'b0;
        read_control_done        = 1'b0;
        read_user_data_available = 1'b0;
        read_user_buffer_data    = 32'h0;
        wr_active = 0; rd_active = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                wr_active = 0; rd_active = 0;
                write_control_done = 1'b0;
                read_control_done  = 1'b0;
            end else begin
                if (write_control_go) begin
                    wr_active = 1;
                    wr_base   = int'(write_control_write_base >> 2);
                    wr_n      = int'(write_control_write_length >> 2);
                    wr_cnt    = 0;
                    wr_delay  = $urandom_range(0, 3);
                    write_control_done = 1'b0;
                end
                if (write_user_write_buffer) begin
                    check("wr_while_full", write_user_buffer_full, 0);
                    mem[(wr_base + wr_cnt) & 32'h03FF_FFFF] = write_user_buffer_data;
                    wr_cnt++;
                    wr_total++;
                end
                if (read_control_go) begin
                    rd_active = 1;
                    rd_base   = int'(read_control_read_base >> 2);
                    rd_n      = int'(read_control_read_length >> 2);
                    rd_i      = 0;
                    rd_cyc    = 0;
                    read_control_done = 1'b0;
                end
                if (read_user_read_buffer) begin
                    check("pop_avail", read_user_data_available, 1);
                    rd_i++;
                    pop_total++;
                end
            end
            @(posedge clk);
            #1;
            write_user_buffer_full = gaps && ($urandom_range(0, 2) == 0);
            if (wr_active && wr_cnt >= wr_n) begin
                if (wr_delay == 0) write_control_done = 1'b1;
                else wr_delay--;
            end
            rd_cyc++;
            if (rd_active && rd_cyc >= rd_n + 2) read_control_done = 1'b1;
            read_user_data_available = rd_active && rd_i < rd_n &&
                                       (!gaps || $urandom_range(0, 2) != 0);
            if (read_user_data_available) begin
                int unsigned k;
                k = (rd_base + rd_i) & 32'h03FF_FFFF;
                read_user_buffer_data = mem.exists(k) ? mem[k] : 32'h0;
                if (corrupt[rd_i]) read_user_buffer_data ^= CMASK;
            end else begin
                read_user_buffer_data = $urandom;
            end
        end
    end

    // Monitor: pops expectations whenever the DUT presents something.
    initial begin
        go_t  g;
        res_t r;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (write_control_go || read_control_go) begin
                    if (exp_goq.size() == 0) begin
                        check("unexpected_go", 1, 0);
                    end else begin
                        g = exp_goq.pop_front();
                        check("go_is_write", write_control_go, g.wr);
                        if (g.wr) begin
                            check("wr_base", write_control_write_base, g.base);
                            check("wr_len", write_control_write_length, g.len);
                            check("wr_fixed", write_control_fixed_location, 0);
                        end else begin
                            check("rd_base", read_control_read_base, g.base);
                            check("rd_len", read_control_read_length, g.len);
                            check("rd_fixed", read_control_fixed_location, 0);
                        end
                    end
                end
                if (write_user_write_buffer) begin
                    if (exp_wq.size() == 0) check("unexpected_write", 1, 0);
                    else check("wr_data", write_user_buffer_data, exp_wq.pop_front());
                end
                if (done) begin
                    if (exp_res.size() == 0) begin
                        check("unexpected_done", 1, 0);
                    end else begin
                        r = exp_res.pop_front();
                        check("cfg_error", cfg_error, r.cfg);
                        check("error_count", error_count, r.ec);
                        check("first_err_addr", first_err_addr, r.fa);
                        check("last_read_data", last_read_data, r.ld);
                    end
                end
            end
        end
    end

    int r_go_at, r_done_at, r_wfirst, r_wlast, r_nwr, r_npop;

    task automatic run(input logic [1:0] m, input logic [27:0] b,
                       input logic [8:0] nw, input logic [31:0] sd,
                       input bit poke);
        int n, w0, p0;
        expect_burst(m, b, nw, sd);
        w0 = wr_total;
        p0 = pop_total;
        r_go_at = 0; r_done_at = 0; r_wfirst = 0; r_wlast = 0;
        mode = m; base_address = b; num_words = nw; seed = sd;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        n = 0;
        while (1) begin
            @(negedge clk);
            n++;
            if (n == 1) check("busy_rise", busy, 1);
            if ((write_control_go || read_control_go) && r_go_at == 0)
                r_go_at = n;
            if (write_user_write_buffer) begin
                if (r_wfirst == 0) r_wfirst = n;
                r_wlast = n;
            end
            if (poke && n == 3) begin
                start = 1'b1; mode = 2'b01; num_words = 9'd5;
                seed = ~sd; base_address = 28'h0;
            end
            if (poke && n == 4) start = 1'b0;
            if (done) begin
                r_done_at = n;
                break;
            end
            if (n >= 20000) begin
                check("done_timeout", n, 0);
                break;
            end
        end
        @(negedge clk);
        check("busy_fall", busy, 0);
        r_nwr  = wr_total - w0;
        r_npop = pop_total - p0;
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_outputs();
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_cfg", cfg_error, 0);
        check("rst_ec", error_count, 0);
        check("rst_fa", first_err_addr, 28'hFFFFFFF);
        check("rst_ld", last_read_data, 0);
        check("rst_wgo", write_control_go, 0);
        check("rst_rgo", read_control_go, 0);
        check("rst_wbuf", write_user_write_buffer, 0);
        check("rst_rbuf", read_user_read_buffer, 0);
        check("rst_wbase", write_control_write_base, 0);
        check("rst_wlen", write_control_write_length, 0);
        check("rst_rbase", read_control_read_base, 0);
        check("rst_rlen", read_control_read_length, 0);
        check("rst_wdata", write_user_buffer_data, 0);
        check("rst_fixed", {write_control_fixed_location,
                            read_control_fixed_location}, 0);
    endtask

    task automatic clear_corrupt();
        for (int i = 0; i < 256; i++) corrupt[i] = 0;
    endtask

    initial begin
        logic [1:0]  m;
        logic [8:0]  nw;
        logic [31:0] sd;
        int          n;
        rst_n = 1'b0; start = 1'b0; mode = 2'b00;
        base_address = '0; num_words = '0; seed = '0;
        gaps = 0;
        clear_corrupt();
        exp_cfg = 0; exp_ec = 0; exp_fa = '1; exp_ld = 0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_outputs();
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;

        run(2'b00, 28'h100, 9'd4, 32'hDEAD0000, 0);
        check("t1_go_latency", r_go_at, 1);
        check("t1_first_write", r_wfirst, 2);
        check("t1_last_write", r_wlast, 5);
        check("t1_nwrites", r_nwr, 4);

        run(2'b10, 28'h400, 9'd8, 32'h12345678, 0);
        check("t2_ec", error_count, 0);
        check("t2_fa", first_err_addr, 28'hFFFFFFF);
        check("t2_ld", last_read_data, 32'h1234567F);

        corrupt[3] = 1; corrupt[5] = 1;
        run(2'b10, 28'h200, 9'd8, 32'hCAFE0000, 0);
        clear_corrupt();
        check("t3_ec", error_count, 2);
        check("t3_fa", first_err_addr, 28'h20C);

        gaps = 1;
        run(2'b10, 28'h1000, 9'd256, $urandom, 0);
        check("t4_nwr", r_nwr, 256);
        check("t4_npop", r_npop, 256);
        corrupt[0] = 1; corrupt[255] = 1;
        run(2'b11, 28'h1000, 9'd256, 32'h5, 0);
        clear_corrupt();
        run(2'b01, 28'h1003, 9'd16, 32'h0, 0);
        check("t4_npop16", r_npop, 16);
        gaps = 0;

        run(2'b00, 28'h0, 9'd0, 32'h1, 0);
        check("t5_n0_done", r_done_at, 2);
        check("t5_n0_nogo", r_go_at, 0);
        check("t5_n0_cfg", cfg_error, 1);
        run(2'b10, 28'h40, 9'd257, 32'h1, 0);
        check("t5_big_done", r_done_at, 2);
        check("t5_big_nogo", r_go_at, 0);
        check("t5_big_nwr", r_nwr + r_npop, 0);
        run(2'b01, 28'h100, 9'd4, 32'h0, 0);
        check("t5_cfg_clear", cfg_error, 0);

        run(2'b10, 28'h3000, 9'd20, 32'hA5A50000, 1);
        check("t6_poke_nwr", r_nwr, 20);
        run(2'b10, 28'hFFFFFF0, 9'd8, 32'h77, 0);

        for (int k = 0; k < 8; k++) begin
            m    = 2'($urandom_range(0, 3));
            nw   = 9'($urandom_range(1, 64));
            sd   = $urandom;
            gaps = $urandom_range(0, 1) == 1;
            for (int i = 0; i < int'(nw); i++)
                corrupt[i] = $urandom_range(0, 15) == 0;
            run(m, 28'($urandom_range(0, 16383)), nw, sd, 0);
            clear_corrupt();
        end
        gaps = 0;

        expect_burst(2'b00, 28'h0F00_0000, 9'd32, 32'h9000);
        mode = 2'b00; base_address = 28'h0F00_0000;
        num_words = 9'd32; seed = 32'h9000;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        n = 0;
        while (n < 50 && !(write_user_write_buffer && n >= 6)) begin
            @(negedge clk);
            n++;
        end
        check("t7_in_wr_data", write_user_write_buffer, 1);
        @(posedge clk);
        #1 rst_n = 1'b0;
        exp_wq.delete();
        exp_res.delete();
        exp_goq.delete();
        exp_cfg = 0; exp_ec = 0; exp_fa = '1; exp_ld = 0;
        @(negedge clk);
        check_reset_outputs();
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;
        run(2'b10, 28'h0F00_0000, 9'd32, 32'h4242_0000, 0);
        check("t7_nwr", r_nwr, 32);
        check("t7_npop", r_npop, 32);
        check("t7_ld", last_read_data, 32'h4242_001F);

        repeat (4) @(posedge clk);
        check("q_empty", exp_wq.size() + exp_res.size() + exp_goq.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
